pass_done_collector: RTL and testbench

//   Receiving end of pass_done_ifc: consumes MTC0 result reports driven by mips_core each cycle.

---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/pass_done_ifc.sv | 10 +
 rtl/pass_done_fifo.sv | 54 +++++
 rtl/pass_done_collector.sv | 129 ++++++++++++
 tb/tb_pass_done_collector.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the pass_done reporting path: MTC0 result codes,
// collector FSM states and the buffered report payload.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MTC0_NOOP = 2'd0,
    MTC0_PASS = 2'd1,
    MTC0_FAIL = 2'd2,
    MTC0_DONE = 2'd3
  } MTC0Code;

  typedef enum logic [1:0] {
    COL_RUN    = 2'd0,
    COL_DRAIN  = 2'd1,
    COL_HALTED = 2'd2
  } collector_state_t;

  typedef struct packed {
    MTC0Code     code;
    logic [15:0] value;
  } pass_done_report_t;

  // Any code other than NOOP is a report worth tallying.
  function automatic logic is_report(input MTC0Code code);
    return code != MTC0_NOOP;
  endfunction

endpackage

// File: rtl/pass_done_ifc.sv
// Per-cycle MTC0 result report from mips_core to the pass_done collector.
interface pass_done_ifc;
  import mips_cpu_pkg::*;

  MTC0Code     code;
  logic [15:0] value;

  modport in  (input  code, value);
  modport out (output code, value);
endinterface

// File: rtl/pass_done_fifo.sv
// Synchronous report FIFO; a push into a full FIFO succeeds only alongside a pop.
module pass_done_fifo
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  pass_done_report_t push_data,
  output logic              full,
  input  logic              pop,
  output logic              empty,
  output pass_done_report_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pass_done_report_t mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push_c;
  logic              do_pop_c;

  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign head      = mem[rd_ptr];
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pass_done_collector.sv
// Collects MTC0 pass/fail/done reports: tallies, first-fail capture, report FIFO
// and end-of-test detection. Define PASS_DONE_TIMEOUT_EN to add the RUN watchdog.
module pass_done_collector
  import mips_cpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  pass_done_ifc.in         pass_done,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output MTC0Code          rpt_code,
  output logic [15:0]      rpt_value,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             first_fail_valid,
  output logic [15:0]      first_fail_value,
  output logic             done,
  output logic             all_passed,
  output logic             timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  collector_state_t  state;
  pass_done_report_t in_rpt_c;
  pass_done_report_t head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic              accept_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic              timeout_hit_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_rpt_c.code  = pass_done.code;
  assign in_rpt_c.value = pass_done.value;
  assign accept_c       = is_report(pass_done.code) && (state != COL_HALTED);
  assign pop_c          = rpt_valid && rpt_ready;
  assign push_c         = accept_c && (!fifo_full_c || pop_c);
  assign drop_c         = accept_c && !push_c;

  assign rpt_valid  = !fifo_empty_c;
  assign rpt_code   = head_c.code;
  assign rpt_value  = head_c.value;
  assign done       = state == COL_HALTED;
  assign all_passed = done && (fail_count == '0) && (pass_count != '0) && !timeout;

  pass_done_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (in_rpt_c),
    .full      (fifo_full_c),
    .pop       (pop_c),
    .empty     (fifo_empty_c),
    .head      (head_c)
  );

  // FSM, tallies and first-fail capture; dropped reports are still tallied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= COL_RUN;
      pass_count       <= '0;
      fail_count       <= '0;
      drop_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_value <= '0;
    end else begin
      if (accept_c) begin
        case (pass_done.code)
          MTC0_PASS: pass_count <= sat_inc(pass_count);
          MTC0_FAIL: begin
            fail_count <= sat_inc(fail_count);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_value <= pass_done.value;
            end
          end
          default: ;
        endcase
      end
      if (drop_c) drop_count <= sat_inc(drop_count);

      // The DONE entry itself must leave the FIFO before halting.
      case (state)
        COL_RUN: begin
          if ((accept_c && pass_done.code == MTC0_DONE) || timeout_hit_c) state <= COL_DRAIN;
        end
        COL_DRAIN: begin
          if (fifo_empty_c && !accept_c) state <= COL_HALTED;
        end
        default: state <= COL_HALTED;
      endcase
    end
  end

`ifdef PASS_DONE_TIMEOUT_EN
  logic [TW-1:0] cyc_cnt;

  assign timeout_hit_c = (state == COL_RUN) && (cyc_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts only while waiting for DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == COL_RUN) cyc_cnt <= cyc_cnt + TW'(1);
      if (timeout_hit_c) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg_c;

  assign unused_timeout_cfg_c = |TW'(TIMEOUT_CYCLES);
  assign timeout_hit_c        = 1'b0;
  assign timeout              = 1'b0;
`endif

endmodule

// File: tb/tb_pass_done_collector.sv
// Self-checking bench for pass_done_collector: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_pass_done_collector;
  import mips_cpu_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned TO    = 100;
  localparam int          SAT   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rpt_ready = 1'b0;
  logic              rpt_valid;
  MTC0Code           rpt_code;
  logic [15:0]       rpt_value;
  logic [CW-1:0]     pass_count;
  logic [CW-1:0]     fail_count;
  logic [CW-1:0]     drop_count;
  logic              first_fail_valid;
  logic [15:0]       first_fail_value;
  logic              done;
  logic              all_passed;
  logic              timeout;

  pass_done_ifc pd ();

  pass_done_collector #(
    .FIFO_DEPTH     (DEPTH),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pass_done        (pd),
    .rpt_valid        (rpt_valid),
    .rpt_ready        (rpt_ready),
    .rpt_code         (rpt_code),
    .rpt_value        (rpt_value),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .drop_count       (drop_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_value (first_fail_value),
    .done             (done),
    .all_passed       (all_passed),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  pass_done_report_t m_q[$];
  pass_done_report_t m_out[$];
  pass_done_report_t got[$];
  int m_pass, m_fail, m_drop, m_ff_value, m_cyc;
  bit m_ff_valid, m_drain, m_halted, m_to;

  function automatic bit m_all_passed();
    return m_halted && m_fail == 0 && m_pass != 0 && !m_to;
  endfunction

  task automatic model_reset();
    m_q.delete(); m_out.delete(); got.delete();
    m_pass = 0; m_fail = 0; m_drop = 0; m_ff_value = 0; m_cyc = 0;
    m_ff_valid = 0; m_drain = 0; m_halted = 0; m_to = 0;
  endtask

  task automatic model_edge(input MTC0Code c, input logic [15:0] v, input logic r);
    bit pop, acc, was_empty, end_now;
    pass_done_report_t e;
    pop       = (m_q.size() != 0) && r;
    acc       = (c != MTC0_NOOP) && !m_halted;
    was_empty = m_q.size() == 0;
    end_now   = 0;
    if (pop) m_out.push_back(m_q.pop_front());
    if (acc) begin
      if (c == MTC0_PASS && m_pass < SAT) m_pass++;
      if (c == MTC0_FAIL) begin
        if (m_fail < SAT) m_fail++;
        if (!m_ff_valid) begin m_ff_valid = 1; m_ff_value = int'(v); end
      end
      if (c == MTC0_DONE) end_now = 1;
      e.code = c; e.value = v;
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else if (m_drop < SAT) m_drop++;
    end
    if (!m_drain) begin
`ifdef PASS_DONE_TIMEOUT_EN
      m_cyc++;
      if (m_cyc == int'(TO)) begin m_to = 1; end_now = 1; end
`endif
      if (end_now) m_drain = 1;
    end else if (!m_halted && was_empty && !acc) begin
      m_halted = 1;
    end
  endtask

  // One clock: drive inputs, log DUT pops, step the model, sample after the edge.
  task automatic cycle(input MTC0Code c, input logic [15:0] v, input logic r);
    pass_done_report_t e;
    pd.code = c; pd.value = v; rpt_ready = r;
    #1;
    if (rpt_valid && rpt_ready) begin
      e.code = rpt_code; e.value = rpt_value;
      got.push_back(e);
    end
    @(posedge clk);
    model_edge(c, v, r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pd.code = MTC0_NOOP; pd.value = '0; rpt_ready = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && !done; i++) cycle(MTC0_NOOP, 16'h0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL reset_rpt_valid got %0b want 0", rpt_valid); end
    checks++; if ({pass_count, fail_count, drop_count} !== '0) begin errors++; $display("FAIL reset_counts got %h want 0", {pass_count, fail_count, drop_count}); end
    checks++; if ({first_fail_valid, first_fail_value} !== '0) begin errors++; $display("FAIL reset_first_fail got %h want 0", {first_fail_valid, first_fail_value}); end
    checks++; if ({done, all_passed, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {done, all_passed, timeout}); end
  endtask

  task automatic test_all_pass();
    do_reset();
    cycle(MTC0_PASS, 16'd1, 1'b1);
    cycle(MTC0_PASS, 16'd2, 1'b1);
    cycle(MTC0_DONE, 16'd0, 1'b1);
    drain(20);
    checks++; if (pass_count !== CW'(2) || fail_count !== CW'(0)) begin errors++; $display("FAIL all_pass_counts got %0d/%0d want 2/0", pass_count, fail_count); end
    checks++; if (done !== 1'b1 || all_passed !== 1'b1) begin errors++; $display("FAIL all_pass_flags got done=%0b ap=%0b want 1/1", done, all_passed); end
    checks++;
    if (got.size() != 3 || got[0].value !== 16'd1 || got[1].value !== 16'd2 || got[2].code !== MTC0_DONE) begin
      errors++; $display("FAIL all_pass_order got %0d entries want 3 (1,2,DONE)", got.size());
    end
  endtask

  task automatic test_first_fail();
    do_reset();
    cycle(MTC0_PASS, 16'h0011, 1'b1);
    cycle(MTC0_FAIL, 16'h00AB, 1'b1);
    cycle(MTC0_FAIL, 16'h00CD, 1'b1);
    cycle(MTC0_DONE, 16'h0000, 1'b1);
    drain(20);
    checks++; if (fail_count !== CW'(2) || pass_count !== CW'(1)) begin errors++; $display("FAIL first_fail_counts got %0d/%0d want 1/2", pass_count, fail_count); end
    checks++; if (first_fail_valid !== 1'b1 || first_fail_value !== 16'h00AB) begin errors++; $display("FAIL first_fail_value got %0b/%h want 1/00ab", first_fail_valid, first_fail_value); end
    checks++; if (done !== 1'b1 || all_passed !== 1'b0) begin errors++; $display("FAIL first_fail_flags got done=%0b ap=%0b want 1/0", done, all_passed); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 10; i++) cycle(MTC0_PASS, 16'(i), 1'b0);
    checks++; if (drop_count !== CW'(2) || pass_count !== CW'(10)) begin errors++; $display("FAIL overflow_counts got drop=%0d pass=%0d want 2/10", drop_count, pass_count); end
    checks++; if (rpt_valid !== 1'b1 || rpt_value !== 16'd1) begin errors++; $display("FAIL overflow_head got %0b/%0d want 1/1", rpt_valid, rpt_value); end
    for (int i = 0; i < 8; i++) cycle(MTC0_NOOP, 16'h0, 1'b1);
    checks++; if (rpt_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty got %0b want 0", rpt_valid); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size() || got[i].value !== 16'(i + 1)) begin
        errors++; $display("FAIL overflow_order idx %0d got %0d want %0d", i, (i < got.size()) ? int'(got[i].value) : -1, i + 1);
      end
    end
  endtask

  task automatic test_done_hold();
    do_reset();
    cycle(MTC0_DONE, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(MTC0_NOOP, 16'h0, 1'b0);
      checks++; if (done !== 1'b0 || rpt_valid !== 1'b1) begin errors++; $display("FAIL hold_wait cyc %0d got done=%0b valid=%0b want 0/1", i, done, rpt_valid); end
    end
    cycle(MTC0_NOOP, 16'h0, 1'b1);
    checks++; if (done !== 1'b0 || rpt_valid !== 1'b0) begin errors++; $display("FAIL hold_popped got done=%0b valid=%0b want 0/0", done, rpt_valid); end
    cycle(MTC0_NOOP, 16'h0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got %0b want 1", done); end
    cycle(MTC0_PASS, 16'h5, 1'b1);
    cycle(MTC0_NOOP, 16'h0, 1'b1);
    checks++; if (pass_count !== CW'(0) || rpt_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL hold_halted got pass=%0d valid=%0b done=%0b want 0/0/1", pass_count, rpt_valid, done); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    cycle(MTC0_PASS, 16'h1, 1'b0);
    cycle(MTC0_PASS, 16'h2, 1'b0);
    cycle(MTC0_DONE, 16'h0, 1'b0);
    checks++; if (pass_count !== CW'(2) || rpt_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got pass=%0d valid=%0b want 2/1", pass_count, rpt_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rpt_valid, rpt_value, pass_count, fail_count, drop_count, first_fail_valid, done, all_passed, timeout} !== '0) begin
      errors++; $display("FAIL mid_reset got valid=%0b val=%h pass=%0d done=%0b want all 0", rpt_valid, rpt_value, pass_count, done);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(MTC0_PASS, 16'h7, 1'b1);
    cycle(MTC0_DONE, 16'h0, 1'b1);
    drain(20);
    checks++; if (done !== 1'b1 || pass_count !== CW'(1) || all_passed !== 1'b1) begin errors++; $display("FAIL mid_rerun got done=%0b pass=%0d ap=%0b want 1/1/1", done, pass_count, all_passed); end
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef PASS_DONE_TIMEOUT_EN
    for (int i = 0; i < int'(TO) - 1; i++) cycle(MTC0_PASS, 16'(i), 1'b1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b want 0", timeout); end
    cycle(MTC0_NOOP, 16'h0, 1'b1);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_hit got %0b want 1", timeout); end
    drain(20);
    checks++; if (done !== 1'b1 || all_passed !== 1'b0) begin errors++; $display("FAIL timeout_done got done=%0b ap=%0b want 1/0", done, all_passed); end
`else
    for (int i = 0; i < int'(TO) + 50; i++) cycle(MTC0_PASS, 16'(i), 1'b1);
    checks++; if (timeout !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL timeout_off got to=%0b done=%0b want 0/0", timeout, done); end
`endif
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int n = 0; n < 200; n++) begin
        int r;
        MTC0Code c;
        logic rdy;
        r   = int'($urandom_range(0, 99));
        c   = (r < 45) ? MTC0_NOOP : (r < 75) ? MTC0_PASS : (r < 97) ? MTC0_FAIL : MTC0_DONE;
        rdy = (round == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        cycle(c, 16'($urandom), rdy);
        checks++;
        if (pass_count !== CW'(m_pass) || fail_count !== CW'(m_fail) || drop_count !== CW'(m_drop)) begin
          errors++; $display("FAIL rand_counts r%0d n%0d got %0d/%0d/%0d want %0d/%0d/%0d", round, n, pass_count, fail_count, drop_count, m_pass, m_fail, m_drop);
        end
        checks++;
        if (first_fail_valid !== m_ff_valid || (m_ff_valid && first_fail_value !== 16'(m_ff_value))) begin
          errors++; $display("FAIL rand_first_fail r%0d n%0d got %0b/%h want %0b/%h", round, n, first_fail_valid, first_fail_value, m_ff_valid, 16'(m_ff_value));
        end
        checks++;
        if (done !== m_halted || all_passed !== m_all_passed() || timeout !== m_to) begin
          errors++; $display("FAIL rand_flags r%0d n%0d got %b want %b", round, n, {done, all_passed, timeout}, {m_halted, m_all_passed(), m_to});
        end
        checks++;
        if (rpt_valid !== (m_q.size() != 0) || (m_q.size() != 0 && {rpt_code, rpt_value} !== m_q[0])) begin
          errors++; $display("FAIL rand_head r%0d n%0d got %0b/%h want %0b", round, n, rpt_valid, {rpt_code, rpt_value}, m_q.size() != 0);
        end
      end
      checks++;
      if (got.size() != m_out.size() || got != m_out) begin
        errors++; $display("FAIL rand_stream r%0d got %0d entries want %0d", round, got.size(), m_out.size());
      end
    end
  endtask

  initial begin
    pd.code = MTC0_NOOP;
    pd.value = '0;
    test_reset();
    test_all_pass();
    test_first_fail();
    test_overflow();
    test_done_hold();
    test_reset_mid_drain();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
